// File: rtl/sram_mem_ctrl_if.sv
// CPU-side request/response bundle between the MEM stage and the SRAM controller.
// The master side (pipeline) issues loads/stores; the slave side (controller)
// returns load data and the ready/freeze indication.
interface sram_mem_ctrl_if;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output wrEn, rdEn, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  wrEn, rdEn, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller that splits one 32-bit load/store into two 16-bit
// half-word phases on an asynchronous SRAM. Each phase spans WAIT_CYCLES+1
// cycles; in a write the last cycle of a phase deasserts WE# to give the SRAM
// address/data hold time. ready is low while an access is in flight.
module sram_mem_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_mem_ctrl_if.slave    bus,
  inout  wire  [15:0]       sramDq,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramWeN,
  output logic              sramOeN
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // Terminal count of a half-word phase (WAIT_CYCLES is at most 15).
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic              req;
  logic [ADDR_W-2:0] word_addr;

  // Request detection and byte-to-half-word address translation; the word
  // index wraps silently for addresses outside the mapped window.
  assign req       = bus.rdEn | bus.wrEn;
  assign word_addr = (ADDR_W-1)'((bus.address - 32'(BASE_ADDR)) >> 2);

  // Freeze indication: pending request in IDLE, busy in LO/HI, released in DONE.
  assign bus.ready = (state == IDLE) ? ~req : (state == DONE);

  // Data bus is only driven during the phases of a write.
  assign sramDq = dq_oe ? dq_out : 16'bz;

  // Access sequencer with registered SRAM strobes, address and load data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_wr        <= 1'b0;
      dq_oe        <= 1'b0;
      sramWeN      <= 1'b1;
      sramOeN      <= 1'b1;
      sramAddr     <= '0;
      bus.readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous load and store is treated as a store.
            op_wr    <= bus.wrEn;
            state    <= LO;
            cnt      <= '0;
            sramAddr <= {word_addr, 1'b0};
            dq_out   <= bus.writeData[15:0];
            dq_oe    <= bus.wrEn;
            sramWeN  <= ~bus.wrEn;
            sramOeN  <= bus.wrEn;
          end
        end
        LO, HI: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!op_wr) begin
              if (state == LO) bus.readData[15:0]  <= sramDq;
              else             bus.readData[31:16] <= sramDq;
            end
            if (state == LO) begin
              state       <= HI;
              sramAddr[0] <= 1'b1;
              dq_out      <= bus.writeData[31:16];
              sramWeN     <= ~op_wr;
            end else begin
              state   <= DONE;
              dq_oe   <= 1'b0;
              sramWeN <= 1'b1;
              sramOeN <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
            // WE# stays low until the final (hold) cycle of the phase.
            sramWeN <= ~(op_wr && ((cnt + 4'd1) < LAST));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: a WAIT_CYCLES=1 instance backed by a small
// SRAM model, plus a WAIT_CYCLES=3 instance for the longer-latency case.
module tb_sram_mem_ctrl;

  logic clk;
  logic rst;

  sram_mem_ctrl_if bus();
  sram_mem_ctrl_if b3();

  wire  [15:0] sramDq;
  logic [17:0] sramAddr;
  logic        sramWeN;
  logic        sramOeN;

  wire  [15:0] s3Dq;
  logic [17:0] s3Addr;
  logic        s3WeN;
  logic        s3OeN;

  int total = 0;
  int bad   = 0;

  // SRAM model (16 half-words, indexed by the low address bits) plus a probe
  // driver used to show that the controller has released the data bus.
  logic [15:0] mem [0:15];
  logic        probe_en;
  logic        sram_drv;
  logic [15:0] sram_q;

  assign sram_drv = !sramOeN && sramWeN;
  assign sram_q   = mem[sramAddr[3:0]];
  assign sramDq   = sram_drv ? sram_q : (probe_en ? 16'h5A3C : 16'bz);

  always @(posedge clk) begin
    if (!sramWeN) mem[sramAddr[3:0]] <= sramDq;
  end

  sram_mem_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sramDq(sramDq), .sramAddr(sramAddr), .sramWeN(sramWeN), .sramOeN(sramOeN)
  );

  sram_mem_ctrl #(.ADDR_W(18), .WAIT_CYCLES(3), .BASE_ADDR(1024)) dut3 (
    .clk(clk), .rst(rst), .bus(b3),
    .sramDq(s3Dq), .sramAddr(s3Addr), .sramWeN(s3WeN), .sramOeN(s3OeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Per-cycle trace of the SRAM bus while ready is low (index 0 = IDLE cycle).
  logic [17:0] tr_addr [0:15];
  logic        tr_we   [0:15];
  logic        tr_oe   [0:15];
  logic [15:0] tr_dq   [0:15];

  // Called just after a falling edge; returns just after the falling edge of
  // the ready=1 (DONE) cycle with the number of ready=0 cycles seen.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, output int lowc);
    bus.wrEn      = wr;
    bus.rdEn      = rd;
    bus.address   = a;
    bus.writeData = wd;
    lowc = 0;
    #1;
    while (!bus.ready && lowc < 40) begin
      if (lowc < 16) begin
        tr_addr[lowc] = sramAddr;
        tr_we[lowc]   = sramWeN;
        tr_oe[lowc]   = sramOeN;
        tr_dq[lowc]   = sramDq;
      end
      lowc++;
      @(negedge clk);
      #1;
    end
  endtask

  int lowc;
  int n3;
  int we3;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    probe_en = 1'b0;
    rst = 1'b0;
    bus.wrEn = 1'b1; bus.rdEn = 1'b0; bus.address = 32'd1032; bus.writeData = 32'hDEAD_BEEF;
    b3.wrEn = 1'b0; b3.rdEn = 1'b0; b3.address = 32'd0; b3.writeData = 32'd0;

    // Reset held with a store request pending: nothing may start.
    repeat (3) @(negedge clk);
    probe_en = 1'b1;
    #1;
    chk("rst_wen", {31'd0, sramWeN}, 32'd1);
    chk("rst_oen", {31'd0, sramOeN}, 32'd1);
    chk("rst_rdata", bus.readData, 32'd0);
    chk("rst_addr", {14'd0, sramAddr}, 32'd0);
    chk("rst_dq_released", {16'd0, sramDq}, 32'h5A3C);
    chk("rst_ready_req", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_still_idle_wen", {31'd0, sramWeN}, 32'd1);
    probe_en = 1'b0;

    // Store 0xDEADBEEF at byte 1024+8 once reset is released.
    rst = 1'b1;
    do_access(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, lowc);
    chk("st_low_cycles", lowc, 32'd5);
    chk("st_addr_lo0", {14'd0, tr_addr[1]}, 32'd4);
    chk("st_addr_lo1", {14'd0, tr_addr[2]}, 32'd4);
    chk("st_addr_hi0", {14'd0, tr_addr[3]}, 32'd5);
    chk("st_addr_hi1", {14'd0, tr_addr[4]}, 32'd5);
    chk("st_we_pattern", {28'd0, tr_we[1], tr_we[2], tr_we[3], tr_we[4]}, 32'b0101);
    chk("st_oe_pattern", {28'd0, tr_oe[1], tr_oe[2], tr_oe[3], tr_oe[4]}, 32'b1111);
    chk("st_dq_lo", {16'd0, tr_dq[1]}, 32'h0000_BEEF);
    chk("st_dq_hi", {16'd0, tr_dq[3]}, 32'h0000_DEAD);
    chk("st_done_wen", {31'd0, sramWeN}, 32'd1);
    chk("st_rdata_unchanged", bus.readData, 32'd0);
    bus.wrEn = 1'b0;
    @(negedge clk);
    #1;
    chk("st_idle_ready", {31'd0, bus.ready}, 32'd1);
    chk("st_mem_lo", {16'd0, mem[4]}, 32'h0000_BEEF);
    chk("st_mem_hi", {16'd0, mem[5]}, 32'h0000_DEAD);

    // Load back the same word.
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, lowc);
    chk("ld_low_cycles", lowc, 32'd5);
    chk("ld_oe_pattern", {28'd0, tr_oe[1], tr_oe[2], tr_oe[3], tr_oe[4]}, 32'b0000);
    chk("ld_we_pattern", {28'd0, tr_we[1], tr_we[2], tr_we[3], tr_we[4]}, 32'b1111);
    chk("ld_dq_lo", {16'd0, tr_dq[1]}, 32'h0000_BEEF);
    chk("ld_dq_hi", {16'd0, tr_dq[3]}, 32'h0000_DEAD);
    chk("ld_rdata", bus.readData, 32'hDEAD_BEEF);
    chk("ld_done_oen", {31'd0, sramOeN}, 32'd1);
    bus.rdEn = 1'b0;
    @(negedge clk);

    // Load and store together: the store wins and readData is untouched.
    do_access(1'b1, 1'b1, 32'd1036, 32'h1234_5678, lowc);
    chk("rw_low_cycles", lowc, 32'd5);
    chk("rw_is_write", {31'd0, tr_we[1]}, 32'd0);
    chk("rw_addr_lo", {14'd0, tr_addr[1]}, 32'd6);
    chk("rw_rdata_kept", bus.readData, 32'hDEAD_BEEF);

    // Back-to-back: load request already present right after DONE.
    bus.wrEn = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_single_ready_gap", {31'd0, bus.ready}, 32'd0);
    do_access(1'b0, 1'b1, 32'd1036, 32'd0, lowc);
    chk("b2b_low_cycles", lowc, 32'd5);
    chk("b2b_rdata", bus.readData, 32'h1234_5678);
    bus.rdEn = 1'b0;
    @(negedge clk);

    // Address below BASE_ADDR wraps to the top of the SRAM.
    do_access(1'b1, 1'b0, 32'd1020, 32'hAAAA_5555, lowc);
    chk("wrap_addr_lo", {14'd0, tr_addr[1]}, 32'h3FFFE);
    chk("wrap_addr_hi", {14'd0, tr_addr[3]}, 32'h3FFFF);
    bus.wrEn = 1'b0;
    @(negedge clk);

    // Reset asserted during the HI phase of a store.
    bus.wrEn = 1'b1; bus.address = 32'd1032; bus.writeData = 32'h0000_0000;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_in_hi_addr", {14'd0, sramAddr}, 32'd5);
    chk("abort_in_hi_wen", {31'd0, sramWeN}, 32'd0);
    rst = 1'b0;
    bus.wrEn = 1'b0;
    probe_en = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_wen", {31'd0, sramWeN}, 32'd1);
    chk("abort_oen", {31'd0, sramOeN}, 32'd1);
    chk("abort_ready", {31'd0, bus.ready}, 32'd1);
    chk("abort_dq_released", {16'd0, sramDq}, 32'h5A3C);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_not_resumed", {31'd0, sramWeN}, 32'd1);
    probe_en = 1'b0;

    // WAIT_CYCLES=3 instance: 9 busy cycles, WE# low 3 of 4 cycles per phase.
    b3.wrEn = 1'b1; b3.address = 32'd1032; b3.writeData = 32'hCAFE_F00D;
    n3 = 0; we3 = 0;
    #1;
    while (!b3.ready && n3 < 40) begin
      if (!s3WeN) we3++;
      n3++;
      @(negedge clk);
      #1;
    end
    chk("w3_low_cycles", n3, 32'd9);
    chk("w3_we_low_cycles", we3, 32'd6);
    chk("w3_done_addr", {14'd0, s3Addr}, 32'd5);
    b3.wrEn = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
